// File: rtl/defdec_pkg.sv
// Shared types for the DeFEC byte path.
// BYTE_W      : byte width in bits
// byte_t      : one byte
// bitcnt_t    : bit position within a byte
// fifo_word_t : byte plus frame-end tag as stored in byte FIFOs
// insert_bit  : writes a bit at a position and clears everything above it
package defdec_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0]         byte_t;
  typedef logic [$clog2(BYTE_W)-1:0] bitcnt_t;

  typedef struct packed {
    logic  last;
    byte_t data;
  } fifo_word_t;

  // Bits above pos are forced to zero, so a byte closed early by a frame
  // end comes out zero padded regardless of what the shifter held.
  function automatic byte_t insert_bit(input byte_t sh, input bitcnt_t pos, input logic b);
    byte_t r;
    r = sh;
    for (int unsigned i = 0; i < BYTE_W; i++) begin
      if (i == 32'(pos)) begin
        r[i] = b;
      end else if (i > 32'(pos)) begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous show-ahead (first-word-fall-through) FIFO.
// clk_h   : clock, rising edge
// rst     : synchronous active-high reset, empties the FIFO
// push_i  : write wdata_i (ignored when full)
// wdata_i : write data
// pop_i   : drop the head entry (ignored when empty)
// rdata_o : head entry, zero when empty
// full_o  : count_o == DEPTH
// empty_o : count_o == 0
// count_o : entries stored, 0..DEPTH
module sync_fifo_fwft #(
  parameter  int unsigned WIDTH = 9,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_h,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally at DEPTH (power of two); the occupancy count
  // is kept separately so full and empty are never ambiguous.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_h) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_h) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/series2parallel_fifo.sv
// Serial-to-parallel byte collector with show-ahead output buffer.
// clk_h  : clock, rising edge
// rst    : synchronous active-high reset
// ival   : input bit valid
// ibit   : serial data bit, LSB of each byte first
// ilast  : frame end, closes the current byte (zero padded)
// ireq   : ready to accept a bit (low only while the buffer is full)
// oval   : byte available at the head
// obyte  : head byte, zero when empty
// olast  : head byte closes a frame
// ordy   : downstream ready, pops on oval & ordy
// ocount : bytes currently buffered
module series2parallel_fifo
  import defdec_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_h,
  input  logic             rst,
  input  logic             ival,
  input  logic             ibit,
  input  logic             ilast,
  output logic             ireq,
  output logic             oval,
  output logic [7:0]       obyte,
  output logic             olast,
  input  logic             ordy,
  output logic [CNT_W-1:0] ocount
);

  byte_t      sh_q, sh_d;
  bitcnt_t    cnt_q, cnt_d;
  logic       accept;
  logic       complete;
  logic       fifo_full;
  logic       fifo_empty;
  fifo_word_t push_word;
  fifo_word_t head_word;

  assign accept   = ival & ireq;
  assign complete = accept & ((cnt_q == '1) | ilast);

  // The pushed byte includes the bit arriving on this edge, so the word
  // is built combinationally rather than taken from the shifter.
  assign push_word.data = insert_bit(sh_q, cnt_q, ibit);
  assign push_word.last = ilast;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (complete) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (accept) begin
      sh_d  = push_word.data;
      cnt_d = cnt_q + bitcnt_t'(1);
    end
  end

  always_ff @(posedge clk_h) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH ($bits(fifo_word_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_h   (clk_h),
    .rst     (rst),
    .push_i  (complete),
    .wdata_i (push_word),
    .pop_i   (ordy),
    .rdata_o (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (ocount)
  );

  // Depends only on registered FIFO state: no path from ival/ordy.
  assign ireq  = ~fifo_full;
  assign oval  = ~fifo_empty;
  assign obyte = head_word.data;
  assign olast = head_word.last;

endmodule

// File: tb/tb_series2parallel_fifo.sv
module tb_series2parallel_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk_h = 1'b0;
  logic             rst   = 1'b1;
  logic             ival  = 1'b0;
  logic             ibit  = 1'b0;
  logic             ilast = 1'b0;
  logic             ordy  = 1'b0;
  logic             ireq;
  logic             oval;
  logic [7:0]       obyte;
  logic             olast;
  logic [CNT_W-1:0] ocount;

  series2parallel_fifo #(.DEPTH(DEPTH)) dut (
    .clk_h  (clk_h),
    .rst    (rst),
    .ival   (ival),
    .ibit   (ibit),
    .ilast  (ilast),
    .ireq   (ireq),
    .oval   (oval),
    .obyte  (obyte),
    .olast  (olast),
    .ordy   (ordy),
    .ocount (ocount)
  );

  always #5 clk_h = ~clk_h;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bits gathered arithmetically into a byte value, bytes
  // held in a queue of {last, data}; pops logged for order comparison.
  int         m_n = 0;
  int         m_acc = 0;
  int         m_pushes = 0;
  bit         m_accepted = 0;
  logic [8:0] m_q[$];
  logic [8:0] m_pops[$];
  logic [8:0] dut_pops[$];

  function automatic logic [CNT_W+10:0] exp_vec();
    logic [8:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 9'h000;
    return {m_q.size() != 0, head[7:0], head[8], CNT_W'(m_q.size()), m_q.size() < DEPTH};
  endfunction

  task automatic cycle(input logic v, input logic b, input logic l, input logic r);
    bit acc, pop;
    ival = v; ibit = b; ilast = l; ordy = r;
    if (!rst && oval === 1'b1 && r) dut_pops.push_back({olast, obyte});
    acc = v && !rst && (m_q.size() < DEPTH);
    pop = r && !rst && (m_q.size() != 0);
    @(posedge clk_h);
    m_accepted = acc;
    if (rst) begin
      m_q.delete(); m_n = 0; m_acc = 0;
    end else begin
      if (pop) m_pops.push_back(m_q.pop_front());
      if (acc) begin
        m_acc += int'(b) << m_n;
        if (m_n == 7 || l) begin
          m_q.push_back({l, 8'(m_acc)});
          m_pushes++; m_n = 0; m_acc = 0;
        end else begin
          m_n++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    m_pops.delete(); dut_pops.delete();
  endtask

  task automatic drain(output bit timed_out);
    int guard = 0;
    timed_out = 0;
    while (m_q.size() != 0 || oval === 1'b1) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      if (++guard > 40) begin timed_out = 1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({oval, obyte, olast, ocount, ireq} !== {1'b1 == 1'b0, 8'h00, 1'b0, CNT_W'(0), 1'b1}) begin
      n_fail++; $display("FAIL reset_state: got %h exp oval=0 obyte=0 olast=0 ocount=0 ireq=1", {oval, obyte, olast, ocount, ireq});
    end
  endtask

  task automatic test_byte();
    logic [7:0] pat = 8'h4D;
    int hi = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, pat[i], 1'b0, 1'b1);
      if (oval === 1'b1) hi++;
      n_checks++;
      if ({oval, obyte, olast, ocount, ireq} !== exp_vec()) begin
        n_fail++; $display("FAIL byte_cycle%0d: got %h exp %h", i, {oval, obyte, olast, ocount, ireq}, exp_vec());
      end
    end
    n_checks++;
    if ({oval, obyte, olast} !== {1'b1, 8'h4D, 1'b0}) begin
      n_fail++; $display("FAIL byte_4D: got oval=%b obyte=%h olast=%b exp 1 4d 0", oval, obyte, olast);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      if (oval === 1'b1) hi++;
    end
    n_checks++;
    if (hi != 1) begin
      n_fail++; $display("FAIL byte_oval_width: oval high %0d cycles exp 1", hi);
    end
  endtask

  task automatic test_partial_last();
    bit to;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, i == 4, 1'b0);
    n_checks++;
    if ({oval, obyte, olast, ocount} !== {1'b1, 8'h1F, 1'b1, CNT_W'(1)}) begin
      n_fail++; $display("FAIL partial_1F: got oval=%b obyte=%h olast=%b ocount=%0d exp 1 1f 1 1", oval, obyte, olast, ocount);
    end
    drain(to);
    n_checks++;
    if (to || oval !== 1'b0) begin
      n_fail++; $display("FAIL partial_drain: oval=%b timeout=%0d exp 0 0", oval, to);
    end
  endtask

  task automatic test_single_bit();
    bit to;
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({oval, obyte, olast} !== {1'b1, 8'h01, 1'b1}) begin
      n_fail++; $display("FAIL single_bit: got oval=%b obyte=%h olast=%b exp 1 01 1", oval, obyte, olast);
    end
    drain(to);
    n_checks++;
    if (to || oval !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: oval=%b timeout=%0d exp 0 0", oval, to);
    end
  endtask

  task automatic test_full();
    logic [7:0] bytes [5] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
    logic [8:0] expo  [5] = '{9'h0A5, 9'h03C, 9'h0FF, 9'h000, 9'h081};
    int  k = 0, guard = 0;
    bit  to;
    logic [7:0] cur;
    m_pops.delete(); dut_pops.delete();
    while (k < 32 && guard < 100) begin
      cur = bytes[k / 8];
      cycle(1'b1, cur[k % 8], 1'b0, 1'b0);
      if (m_accepted) k++;
      guard++;
    end
    for (int i = 0; i < 4; i++) begin
      cur = bytes[4];
      cycle(1'b1, cur[0], 1'b0, 1'b0);
      if (m_accepted) k++;
      n_checks++;
      if ({ireq, ocount} !== {1'b0, CNT_W'(DEPTH)} || {oval, obyte, olast, ocount, ireq} !== exp_vec()) begin
        n_fail++; $display("FAIL full_stall%0d: got ireq=%b ocount=%0d exp 0 %0d", i, ireq, ocount, DEPTH);
      end
    end
    guard = 0;
    while (k < 40 && guard < 100) begin
      cur = bytes[k / 8];
      cycle(1'b1, cur[k % 8], 1'b0, 1'b1);
      if (m_accepted) k++;
      guard++;
      n_checks++;
      if ({oval, obyte, olast, ocount, ireq} !== exp_vec()) begin
        n_fail++; $display("FAIL full_resume: got %h exp %h", {oval, obyte, olast, ocount, ireq}, exp_vec());
      end
    end
    drain(to);
    n_checks++;
    if (to || k != 40) begin
      n_fail++; $display("FAIL full_progress: bits=%0d timeout=%0d exp 40 0", k, to);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= dut_pops.size() || dut_pops[i] !== expo[i]) begin
        n_fail++; $display("FAIL full_order%0d: got %h exp %h (popped %0d)", i,
                           (i < dut_pops.size()) ? dut_pops[i] : 9'h1FF, expo[i], dut_pops.size());
      end
    end
  endtask

  task automatic test_random();
    int  start = m_pushes;
    int  guard = 0;
    bit  l, to, bad;
    m_pops.delete(); dut_pops.delete();
    while (m_pushes - start < 1000 && guard < 12000) begin
      l = (m_n >= 3) && ($urandom_range(7) == 0);
      cycle(1'b1, 1'($urandom_range(1)), l, 1'(guard % 2));
      guard++;
      n_checks++;
      if ({oval, obyte, olast, ocount, ireq} !== exp_vec() || ireq !== 1'b1 || ocount > CNT_W'(2)) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h exp %h (ireq must stay 1, ocount<=2)",
                           guard, {oval, obyte, olast, ocount, ireq}, exp_vec());
      end
    end
    drain(to);
    bad = to || (dut_pops.size() != m_pops.size()) || (m_pops.size() < 1000);
    for (int i = 0; i < dut_pops.size() && !bad; i++) begin
      if (dut_pops[i] !== m_pops[i]) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL random_order: got %0d popped bytes exp %0d in model order (timeout=%0d)",
                         dut_pops.size(), m_pops.size(), to);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    bit to;
    for (int i = 0; i < 19; i++) cycle(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
    n_checks++;
    if (ocount !== CNT_W'(2)) begin
      n_fail++; $display("FAIL rstmid_pre: got ocount=%0d exp 2", ocount);
    end
    rst = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    n_checks++;
    if ({oval, ocount, obyte, olast, ireq} !== {1'b0, CNT_W'(0), 8'h00, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL rstmid_clear: got oval=%b ocount=%0d obyte=%h ireq=%b exp 0 0 00 1", oval, ocount, obyte, ireq);
    end
    v = 8'($urandom);
    for (int i = 0; i < 8; i++) cycle(1'b1, v[i], 1'b0, 1'b0);
    n_checks++;
    if ({oval, obyte, olast, ocount} !== {1'b1, v, 1'b0, CNT_W'(1)}) begin
      n_fail++; $display("FAIL rstmid_clean: got oval=%b obyte=%h olast=%b ocount=%0d exp 1 %h 0 1", oval, obyte, olast, ocount, v);
    end
    drain(to);
  endtask

  initial begin
    test_reset();
    test_byte();
    test_partial_last();
    test_single_bit();
    test_full();
    test_single_bit();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
